dmem_responder: RTL and testbench

- Memory-side responder for the pipeline's data-memory port: it accepts load/store requests from the MEM stage over a valid/ready handshake.
- Serves byte, halfword and word accesses from internal word-organised storage after a programmable latency.
- Returns load data already sign- or zero-extended, ready for write-back (lb/lbu/lh/lhu/lw/sb/sh/sw).
- Replaces the zero-latency DataMem so the stall logic can be exercised against a realistic multi-cycle memory.

---
 rtl/dmem_pkg.sv | 45 ++++
 rtl/dmem_lane_align.sv | 50 +++++
 rtl/dmem_responder.sv | 159 +++++++++++++++
 tb/tb_dmem_responder.sv | 463 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared encodings for the data-memory responder.
// Size codes, FSM states, latency bound and lane-alignment helpers.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam int unsigned MAX_LATENCY = 15;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        RESP = 2'b10
    } dmemState_e;

    // Force the low address bits to the natural alignment of the size.
    // Size 2'b11 is treated as a word.
    function automatic logic [1:0] alignOffset(
        input logic [1:0] size,
        input logic [1:0] off
    );
        logic [1:0] res;
        unique case (size)
            SZ_BYTE: res = off;
            SZ_HALF: res = {off[1], 1'b0};
            default: res = 2'b00;
        endcase
        return res;
    endfunction

    function automatic logic isMisaligned(
        input logic [1:0] size,
        input logic [1:0] off
    );
        logic res;
        unique case (size)
            SZ_BYTE: res = 1'b0;
            SZ_HALF: res = off[0];
            default: res = (off != 2'b00);
        endcase
        return res;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: combinational byte-lane merge for stores and
// extraction/extension for loads on one little-endian 32-bit word.
// Ports:
//   oldWord   in  32  current contents of the addressed word
//   byteOff   in  2   byte offset within the word (already aligned)
//   size      in  2   access size code (11 acts as word)
//   isSigned  in  1   sign-extend loaded byte/half when set
//   wdata     in  32  right-justified store data
//   storeWord out 32  oldWord with the addressed lanes replaced
//   loadData  out 32  selected lanes shifted to bit 0 and extended
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [31:0] oldWord,
    input  logic [1:0]  byteOff,
    input  logic [1:0]  size,
    input  logic        isSigned,
    input  logic [31:0] wdata,
    output logic [31:0] storeWord,
    output logic [31:0] loadData
);

    logic [31:0] shifted;
    logic [4:0]  byteShift;
    logic [4:0]  halfShift;

    assign byteShift = {byteOff, 3'b000};
    assign halfShift = {byteOff[1], 4'b0000};
    assign shifted   = oldWord >> byteShift;

    always_comb begin
        storeWord = oldWord;
        loadData  = oldWord;
        unique case (size)
            SZ_BYTE: begin
                storeWord[byteShift +: 8] = wdata[7:0];
                loadData = {{24{isSigned & shifted[7]}}, shifted[7:0]};
            end
            SZ_HALF: begin
                storeWord[halfShift +: 16] = wdata[15:0];
                loadData = {{16{isSigned & shifted[15]}}, shifted[15:0]};
            end
            default: begin
                storeWord = wdata;
                loadData  = oldWord;
            end
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle data-memory responder for the MEM stage.
// Accepts one load/store over valid/ready, answers after LATENCY cycles.
// Ports:
//   CLK, RST (async, active high)
//   req_valid/req_ready handshake; req_we, req_size, req_signed,
//   req_addr, req_wdata request fields
//   rsp_valid one-cycle pulse, rsp_rdata extended load data (0 on stores)
//   rsp_err misaligned flag, present only with DMEM_MISALIGN_CHECK_EN
// Build option: define DMEM_MISALIGN_CHECK_EN to report and suppress
// misaligned accesses instead of silently aligning them.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 10,
    parameter int unsigned LATENCY    = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
`ifdef DMEM_MISALIGN_CHECK_EN
    output logic        rsp_err,
`endif
    output logic [31:0] rsp_rdata
);

    localparam int unsigned WORDS = 1 << DEPTH_LOG2;
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    dmemState_e state;
    dmemState_e nextState;

    logic [3:0]            count;
    logic                  latWe;
    logic                  latSigned;
    logic [1:0]            latSize;
    logic [1:0]            latOff;
    logic [DEPTH_LOG2-1:0] latIdx;
    logic [31:0]           latWdata;

    logic [31:0] mem [WORDS];

    logic        accept;
    logic        fire;
    logic        commit;
    logic        accessErr;
    logic [1:0]  effOff;
    logic [31:0] oldWord;
    logic [31:0] storeWord;
    logic [31:0] loadData;

    // Address bits above the storage range alias onto the same words.
    logic unusedAddr;
    assign unusedAddr = ^req_addr[31:DEPTH_LOG2+2];

    assign req_ready = (state == IDLE);
    assign accept    = req_ready && req_valid;
    assign fire      = (state == BUSY) && (count == 4'd0);

`ifdef DMEM_MISALIGN_CHECK_EN
    assign accessErr = isMisaligned(latSize, latOff);
`else
    assign accessErr = 1'b0;
`endif

    assign effOff  = alignOffset(latSize, latOff);
    assign oldWord = mem[latIdx];

    // State is reset asynchronously, so a reset during BUSY drops fire
    // immediately and the pending store can never reach the array.
    assign commit = fire && latWe && !accessErr;

    dmem_lane_align uAlign (
        .oldWord  (oldWord),
        .byteOff  (effOff),
        .size     (latSize),
        .isSigned (latSigned),
        .wdata    (latWdata),
        .storeWord(storeWord),
        .loadData (loadData)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        unique case (state)
            IDLE:    if (req_valid) nextState = BUSY;
            BUSY:    if (count == 4'd0) nextState = RESP;
            RESP:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            count     <= 4'd0;
            latWe     <= 1'b0;
            latSigned <= 1'b0;
            latSize   <= SZ_BYTE;
            latOff    <= 2'b00;
            latIdx    <= '0;
            latWdata  <= 32'd0;
        end else if (accept) begin
            count     <= CNT_LOAD;
            latWe     <= req_we;
            latSigned <= req_signed;
            latSize   <= req_size;
            latOff    <= req_addr[1:0];
            latIdx    <= req_addr[DEPTH_LOG2+1:2];
            latWdata  <= req_wdata;
        end else if ((state == BUSY) && (count != 4'd0)) begin
            count <= count - 4'd1;
        end
    end

    // rsp_rdata is held between responses; only rsp_valid is a pulse.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
        end else begin
            rsp_valid <= fire;
            if (fire) begin
                rsp_rdata <= (latWe || accessErr) ? 32'd0 : loadData;
            end
        end
    end

`ifdef DMEM_MISALIGN_CHECK_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rsp_err <= 1'b0;
        end else if (fire) begin
            rsp_err <= accessErr;
        end
    end
`endif

    // Storage is deliberately not reset.
    always_ff @(posedge CLK) begin
        if (commit) begin
            mem[latIdx] <= storeWord;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: randomized and directed checks of dmem_responder
// against a byte-array reference model.
module tb_dmem_responder;

    localparam int LAT      = 2;
    localparam int DLOG2    = 10;
    localparam int MEMBYTES = 4 << DLOG2;

    logic        CLK;
    logic        RST;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
`ifdef DMEM_MISALIGN_CHECK_EN
    logic        rsp_err;
`endif

    int nCmp;
    int nFail;

    bit [7:0] mem8 [MEMBYTES];

    dmem_responder #(
        .DEPTH_LOG2(DLOG2),
        .LATENCY   (LAT)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_size  (req_size),
        .req_signed(req_signed),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
`ifdef DMEM_MISALIGN_CHECK_EN
        .rsp_err   (rsp_err),
`endif
        .rsp_rdata (rsp_rdata)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic bit curErr();
`ifdef DMEM_MISALIGN_CHECK_EN
        return rsp_err;
`else
        return 1'b0;
`endif
    endfunction

    // Reference: memory as bytes, loads built by arithmetic.
    function automatic void modelAccess(
        input  bit        we,
        input  bit [1:0]  size,
        input  bit        sgn,
        input  bit [31:0] addr,
        input  bit [31:0] wdata,
        output bit [31:0] expData,
        output bit        expErr
    );
        int     nb;
        int     base;
        longint v;
        nb   = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        base = int'(addr % MEMBYTES);
        expErr  = (base % nb) != 0;
        expData = 32'd0;
`ifndef DMEM_MISALIGN_CHECK_EN
        if (expErr) begin
            base   = base - (base % nb);
            expErr = 1'b0;
        end
`endif
        if (expErr) return;
        if (we) begin
            for (int i = 0; i < nb; i++)
                mem8[base + i] = wdata[8*i +: 8];
            return;
        end
        v = 0;
        for (int i = 0; i < nb; i++)
            v = v + (longint'(mem8[base + i]) << (8 * i));
        if (sgn && nb < 4 && v >= (longint'(1) << (8 * nb - 1)))
            v = v - (longint'(1) << (8 * nb));
        expData = 32'(v);
    endfunction

    // One handshake; lat = edges from accept to first rsp_valid, -1 on timeout.
    task automatic txn(
        input  bit        we,
        input  bit [1:0]  size,
        input  bit        sgn,
        input  bit [31:0] addr,
        input  bit [31:0] wdata,
        output bit [31:0] rdata,
        output bit        err,
        output int        lat
    );
        int n;
        lat   = -1;
        rdata = 32'd0;
        err   = 1'b0;
        n     = 0;
        while (!req_ready && n < 50) begin
            @(posedge CLK);
            #1;
            n++;
        end
        req_valid  = 1'b1;
        req_we     = we;
        req_size   = size;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wdata;
        @(posedge CLK);
        #1;
        req_valid = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge CLK);
            #1;
            if (rsp_valid) begin
                lat   = c;
                rdata = rsp_rdata;
                err   = curErr();
                break;
            end
        end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        req_valid = 1'b0;
        req_we = 1'b0;
        req_size = 2'b00;
        req_signed = 1'b0;
        req_addr = 32'd0;
        req_wdata = 32'd0;
        repeat (2) @(posedge CLK);
        #1;
        nCmp++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 32'd0
            || curErr() !== 1'b0) begin
            nFail++;
            $display("FAIL reset_state: ready=%b valid=%b rdata=%h err=%b, want 1 0 0 0",
                     req_ready, rsp_valid, rsp_rdata, curErr());
        end
        RST = 1'b0;
        @(posedge CLK);
        #1;
    endtask

    task automatic init_region();
        bit [31:0] rd, ed, w;
        bit        er, ee;
        int        lat;
        for (int i = 0; i < 64; i++) begin
            w = $urandom;
            modelAccess(1'b1, 2'b10, 1'b0, 32'(i * 4), w, ed, ee);
            txn(1'b1, 2'b10, 1'b0, 32'(i * 4), w, rd, er, lat);
            if (lat != LAT) begin
                nCmp++;
                nFail++;
                $display("FAIL init_latency: got %0d want %0d", lat, LAT);
            end
        end
    endtask

    task automatic test_reset_mid_busy();
        bit [31:0] rd, ed;
        bit        er, ee;
        int        lat, pulses;
        pulses = 0;
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_size  = 2'b10;
        req_addr  = 32'h10;
        req_wdata = 32'hDEADBEEF;
        @(posedge CLK);
        #1;
        req_valid = 1'b0;
        @(posedge CLK);
        #1;
        RST = 1'b1;
        @(posedge CLK);
        #1;
        if (rsp_valid) pulses++;
        RST = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(posedge CLK);
            #1;
            if (rsp_valid) pulses++;
        end
        nCmp++;
        if (pulses != 0) begin
            nFail++;
            $display("FAIL rst_busy_pulse: got %0d pulses want 0", pulses);
        end
        nCmp++;
        if (req_ready !== 1'b1) begin
            nFail++;
            $display("FAIL rst_busy_ready: got %b want 1", req_ready);
        end
        modelAccess(1'b0, 2'b10, 1'b0, 32'h10, 32'd0, ed, ee);
        txn(1'b0, 2'b10, 1'b0, 32'h10, 32'd0, rd, er, lat);
        nCmp++;
        if (rd !== ed || lat != LAT) begin
            nFail++;
            $display("FAIL rst_busy_lw: got %h lat %0d want %h lat %0d",
                     rd, lat, ed, LAT);
        end
    endtask

    task automatic test_latency();
        bit [31:0] rd, ed;
        bit        er, ee;
        int        lat;
        modelAccess(1'b1, 2'b10, 1'b0, 32'h20, 32'h11223344, ed, ee);
        txn(1'b1, 2'b10, 1'b0, 32'h20, 32'h11223344, rd, er, lat);
        nCmp++;
        if (lat != LAT) begin
            nFail++;
            $display("FAIL latency_sw: got %0d want %0d", lat, LAT);
        end
        @(posedge CLK);
        #1;
        nCmp++;
        if (rsp_valid !== 1'b0) begin
            nFail++;
            $display("FAIL pulse_width: rsp_valid got %b want 0", rsp_valid);
        end
        modelAccess(1'b0, 2'b10, 1'b0, 32'h20, 32'd0, ed, ee);
        txn(1'b0, 2'b10, 1'b0, 32'h20, 32'd0, rd, er, lat);
        nCmp++;
        if (rd !== 32'h11223344 || lat != LAT) begin
            nFail++;
            $display("FAIL latency_lw: got %h lat %0d want 11223344 lat %0d",
                     rd, lat, LAT);
        end
        @(posedge CLK);
        #1;
        nCmp++;
        if (rsp_rdata !== 32'h11223344) begin
            nFail++;
            $display("FAIL rdata_hold: got %h want 11223344", rsp_rdata);
        end
    endtask

    task automatic test_byte_lanes();
        bit [31:0] rd, ed;
        bit        er, ee;
        int        lat;
        modelAccess(1'b1, 2'b00, 1'b0, 32'h21, 32'hAA, ed, ee);
        txn(1'b1, 2'b00, 1'b0, 32'h21, 32'hAA, rd, er, lat);
        txn(1'b0, 2'b10, 1'b0, 32'h20, 32'd0, rd, er, lat);
        nCmp++;
        if (rd !== 32'h1122AA44) begin
            nFail++;
            $display("FAIL sb_merge: got %h want 1122aa44", rd);
        end
        txn(1'b0, 2'b00, 1'b1, 32'h21, 32'd0, rd, er, lat);
        nCmp++;
        if (rd !== 32'hFFFFFFAA) begin
            nFail++;
            $display("FAIL lb: got %h want ffffffaa", rd);
        end
        txn(1'b0, 2'b00, 1'b0, 32'h21, 32'd0, rd, er, lat);
        nCmp++;
        if (rd !== 32'h000000AA) begin
            nFail++;
            $display("FAIL lbu: got %h want 000000aa", rd);
        end
    endtask

    task automatic test_halfword();
        bit [31:0] rd, ed;
        bit        er, ee;
        int        lat;
        modelAccess(1'b1, 2'b01, 1'b0, 32'h22, 32'h8001, ed, ee);
        txn(1'b1, 2'b01, 1'b0, 32'h22, 32'h8001, rd, er, lat);
        txn(1'b0, 2'b01, 1'b1, 32'h22, 32'd0, rd, er, lat);
        nCmp++;
        if (rd !== 32'hFFFF8001) begin
            nFail++;
            $display("FAIL lh: got %h want ffff8001", rd);
        end
        txn(1'b0, 2'b01, 1'b0, 32'h22, 32'd0, rd, er, lat);
        nCmp++;
        if (rd !== 32'h00008001) begin
            nFail++;
            $display("FAIL lhu: got %h want 00008001", rd);
        end
        txn(1'b0, 2'b10, 1'b0, 32'h20, 32'd0, rd, er, lat);
        nCmp++;
        if (rd !== 32'h8001AA44) begin
            nFail++;
            $display("FAIL sh_merge: got %h want 8001aa44", rd);
        end
    endtask

    task automatic test_misalign();
        bit [31:0] rd, ed;
        bit        er, ee;
        int        lat;
`ifdef DMEM_MISALIGN_CHECK_EN
        txn(1'b0, 2'b10, 1'b0, 32'h22, 32'd0, rd, er, lat);
        nCmp++;
        if (er !== 1'b1 || rd !== 32'd0 || lat != LAT) begin
            nFail++;
            $display("FAIL misalign_lw: err %b rdata %h lat %0d want 1 0 %0d",
                     er, rd, lat, LAT);
        end
        modelAccess(1'b1, 2'b10, 1'b0, 32'h22, 32'hFFFFFFFF, ed, ee);
        txn(1'b1, 2'b10, 1'b0, 32'h22, 32'hFFFFFFFF, rd, er, lat);
        nCmp++;
        if (er !== 1'b1) begin
            nFail++;
            $display("FAIL misalign_sw_err: got %b want 1", er);
        end
        txn(1'b0, 2'b10, 1'b0, 32'h20, 32'd0, rd, er, lat);
        nCmp++;
        if (rd !== 32'h8001AA44 || er !== 1'b0) begin
            nFail++;
            $display("FAIL misalign_sw_kept: got %h err %b want 8001aa44 0", rd, er);
        end
`else
        txn(1'b0, 2'b10, 1'b0, 32'h22, 32'd0, rd, er, lat);
        nCmp++;
        if (rd !== 32'h8001AA44) begin
            nFail++;
            $display("FAIL misalign_lw_aligned: got %h want 8001aa44", rd);
        end
        txn(1'b0, 2'b01, 1'b0, 32'h23, 32'd0, rd, er, lat);
        nCmp++;
        if (rd !== 32'h00008001) begin
            nFail++;
            $display("FAIL misalign_lh_aligned: got %h want 00008001", rd);
        end
`endif
    endtask

    task automatic test_wrap();
        bit [31:0] rd, ed;
        bit        er, ee;
        int        lat;
        modelAccess(1'b1, 2'b10, 1'b0, 32'h1000, 32'h5, ed, ee);
        txn(1'b1, 2'b10, 1'b0, 32'h1000, 32'h5, rd, er, lat);
        txn(1'b0, 2'b10, 1'b0, 32'h0, 32'd0, rd, er, lat);
        nCmp++;
        if (rd !== 32'h5) begin
            nFail++;
            $display("FAIL wrap: got %h want 00000005", rd);
        end
    endtask

    task automatic test_back_to_back();
        int        acc[$];
        bit [31:0] rd[$];
        bit [31:0] ed;
        bit        ee;
        bit        willAccept;
        int        n;
        n = 0;
        while (!req_ready && n < 50) begin
            @(posedge CLK);
            #1;
            n++;
        end
        modelAccess(1'b1, 2'b10, 1'b0, 32'h30, 32'hCAFE0001, ed, ee);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_size   = 2'b10;
        req_signed = 1'b0;
        req_addr   = 32'h30;
        req_wdata  = 32'hCAFE0001;
        for (int cyc = 0; cyc < 30; cyc++) begin
            willAccept = req_valid && req_ready;
            @(posedge CLK);
            #1;
            if (rsp_valid) rd.push_back(rsp_rdata);
            if (willAccept) begin
                acc.push_back(cyc);
                if (acc.size() == 1) begin
                    req_we    = 1'b0;
                    req_wdata = 32'd0;
                end else begin
                    req_valid = 1'b0;
                end
            end
        end
        nCmp++;
        if (acc.size() != 2) begin
            nFail++;
            $display("FAIL b2b_accepts: got %0d want 2", acc.size());
        end else begin
            nCmp++;
            if (acc[1] - acc[0] != LAT + 2) begin
                nFail++;
                $display("FAIL b2b_gap: got %0d want %0d", acc[1] - acc[0], LAT + 2);
            end
        end
        nCmp++;
        if (rd.size() != 2) begin
            nFail++;
            $display("FAIL b2b_rsps: got %0d want 2", rd.size());
        end else begin
            nCmp++;
            if (rd[1] !== 32'hCAFE0001) begin
                nFail++;
                $display("FAIL b2b_data: got %h want cafe0001", rd[1]);
            end
        end
    endtask

    task automatic test_random();
        bit [31:0] rd, ed, addr, wd;
        bit        er, ee, we, sg;
        bit [1:0]  sz;
        int        lat;
        for (int i = 0; i < 300; i++) begin
            we   = 1'($urandom_range(0, 1));
            sz   = 2'($urandom_range(0, 3));
            sg   = 1'($urandom_range(0, 1));
            wd   = $urandom;
            addr = {$urandom_range(0, 1048575), 12'h000}
                   | 32'($urandom_range(0, 255));
            modelAccess(we, sz, sg, addr, wd, ed, ee);
            txn(we, sz, sg, addr, wd, rd, er, lat);
            nCmp++;
            if (rd !== ed || er !== ee || lat != LAT) begin
                nFail++;
                $display("FAIL rand[%0d] we%b sz%0d s%b a%h: got %h err %b lat %0d want %h err %b lat %0d",
                         i, we, sz, sg, addr, rd, er, lat, ed, ee, LAT);
            end
        end
    endtask

    initial begin
        nCmp  = 0;
        nFail = 0;
        test_reset();
        init_region();
        test_reset_mid_busy();
        test_latency();
        test_byte_lanes();
        test_halfword();
        test_misalign();
        test_wrap();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
        $finish;
    end

endmodule
